// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, oversampling constants and
// the baud divisor formula used by both the receiver and transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } uart_state_t;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned HALF       = 8;

   // Clocks per oversample tick, truncated toward zero.
   function automatic int unsigned baud_divisor(input int unsigned clock_hz,
                                                input int unsigned baud);
      return clock_hz / (baud * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample prescaler: one-cycle tick every DIV clocks, restarted by a
// synchronous clear so the first tick lands a full period after the clear.
module uart_baud_tick #(
   parameter int unsigned DIV = 54
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   // Divide-by-DIV counter, wraps on the tick cycle or restarts on clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear || (count == LAST)) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8-bit UART receiver, 16x oversampled, 1 start / 8 data LSB first /
// optional parity / 1 stop. Define UART_RX_PARITY_EN to include the parity
// bit; without it frames are 10 bits and parity_err is constant 0.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
   parameter int unsigned BAUD_RATE       = 115_200,
   parameter int unsigned PARITY_ODD      = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       rxready,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int unsigned DIV       = baud_divisor(CLOCK_FREQUENCY, BAUD_RATE);
   localparam logic [3:0]  TICK_MID  = 4'(HALF - 1);
   localparam logic [3:0]  TICK_LAST = 4'(OVERSAMPLE - 1);
   localparam logic        ODD       = (PARITY_ODD != 0);

   logic        rx_meta;
   logic        rxs;
   logic        rxs_prev;
   logic        tick;
   logic        tick_clear;
   logic        rxs_fall;
   logic        mid_done;
   logic        bit_done;
   uart_state_t state;
   logic [3:0]  tick_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;

`ifdef UART_RX_PARITY_EN
   logic        par_bad;
`else
   logic        unused_parity_cfg;
   assign unused_parity_cfg = ODD;
`endif

   assign rxs_fall   = rxs_prev & ~rxs;
   assign tick_clear = (state == ST_IDLE) && rxs_fall;
   assign mid_done   = tick && (tick_cnt == TICK_MID);
   assign bit_done   = tick && (tick_cnt == TICK_LAST);

   uart_baud_tick #(
      .DIV (DIV)
   ) u_baud_tick (
      .clock (clock),
      .reset (reset),
      .clear (tick_clear),
      .tick  (tick)
   );

   // Two-flop synchronizer plus one delayed copy for falling-edge detect
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_meta  <= 1'b1;
         rxs      <= 1'b1;
         rxs_prev <= 1'b1;
      end else begin
         rx_meta  <= rx;
         rxs      <= rx_meta;
         rxs_prev <= rxs;
      end
   end

   // Frame FSM with sampling datapath and registered one-cycle strobes
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         tick_cnt   <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         dout       <= '0;
         rxready    <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad    <= 1'b0;
`endif
      end else begin
         rxready    <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rxs_fall) begin
                  tick_cnt <= '0;
                  bit_idx  <= '0;
`ifdef UART_RX_PARITY_EN
                  par_bad  <= 1'b0;
`endif
                  state    <= ST_START;
               end
            end
            ST_START: begin
               if (mid_done) begin
                  tick_cnt <= '0;
                  state    <= rxs ? ST_IDLE : ST_DATA;
               end else if (tick) begin
                  tick_cnt <= tick_cnt + 4'd1;
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  tick_cnt <= '0;
                  shreg    <= {rxs, shreg[7:1]};
                  bit_idx  <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= ST_PARITY;
`else
                     state <= ST_STOP;
`endif
                  end
               end else if (tick) begin
                  tick_cnt <= tick_cnt + 4'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (bit_done) begin
                  tick_cnt <= '0;
                  par_bad  <= rxs ^ (^shreg) ^ ODD;
                  state    <= ST_STOP;
               end else if (tick) begin
                  tick_cnt <= tick_cnt + 4'd1;
               end
            end
`endif
            ST_STOP: begin
               if (bit_done) begin
                  tick_cnt <= '0;
                  if (rxs) begin
                     dout    <= shreg;
                     rxready <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     parity_err <= par_bad;
`endif
                     // Leaving at mid-stop lets a back-to-back start bit be caught
                     state   <= ST_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= ST_BREAK;
                  end
               end else if (tick) begin
                  tick_cnt <= tick_cnt + 4'd1;
               end
            end
            ST_BREAK: begin
               // A held-low line must go high before another frame is accepted
               if (rxs) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Frames are generated at bit level and the
// expected output events (kind, byte, cycle) are predicted from the frame
// format and the line rate; observed events are collected and compared.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int CLK_HZ   = 100_000_000;
   localparam int BAUD     = 1_000_000;
   localparam int DIV      = CLK_HZ / (BAUD * 16);   // 6, truncated from 6.25
   localparam int BIT      = 16 * DIV;
   localparam bit PAR_ODD  = 1'b0;
`ifdef UART_RX_PARITY_EN
   localparam int PBITS    = 1;
`else
   localparam int PBITS    = 0;
`endif
   // Ticks from start-bit detect to the stop-bit sample point
   localparam int LAT_TICKS = 8 + 16 * (9 + PBITS);
   // Pin to edge detect: two synchronizer flops plus the detect edge
   localparam int PIPE      = 3;

   typedef struct {
      bit         rdy;
      bit         ferr;
      bit         perr;
      logic [7:0] data;
      int         cyc;
   } ev_t;

   logic       clock;
   logic       reset;
   logic       rx;
   logic [7:0] dout;
   logic       rxready;
   logic       frame_err;
   logic       parity_err;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   logic [7:0] last_good = 8'h00;
   ev_t        exp_q[$];
   ev_t        got_q[$];

   uart_rx #(
      .CLOCK_FREQUENCY (CLK_HZ),
      .BAUD_RATE       (BAUD),
      .PARITY_ODD      (0)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .rx         (rx),
      .dout       (dout),
      .rxready    (rxready),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Cycle counter and output-event monitor, sampled 1 unit after the edge
   always @(posedge clock) begin
      ev_t e;
      cyc = cyc + 1;
      #1;
      if (rxready || frame_err || parity_err) begin
         e.rdy  = rxready;
         e.ferr = frame_err;
         e.perr = parity_err;
         e.data = dout;
         e.cyc  = cyc;
         got_q.push_back(e);
      end
   end

   initial begin
      #4_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit good_parity(input logic [7:0] b);
      return (^b) ^ PAR_ODD;
   endfunction

   task automatic drive_bit(input bit v);
      rx = v;
      repeat (BIT) @(negedge clock);
   endtask

   task automatic line_idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clock);
   endtask

   // Sends one frame starting now (at a negedge) and records the expected event
   task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit pbit);
      ev_t e;
      e.cyc = cyc + PIPE + LAT_TICKS * DIV;
      if (stop_bit) begin
         e.rdy     = 1'b1;
         e.ferr    = 1'b0;
         e.perr    = (PBITS == 1) && (pbit != good_parity(b));
         e.data    = b;
         last_good = b;
      end else begin
         e.rdy  = 1'b0;
         e.ferr = 1'b1;
         e.perr = 1'b0;
         e.data = last_good;
      end
      exp_q.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      if (PBITS == 1) drive_bit(pbit);
      drive_bit(stop_bit);
   endtask

   task automatic send_good(input logic [7:0] b);
      send_frame(b, 1'b1, good_parity(b));
   endtask

   initial begin
      logic [7:0] msg [5];
      logic [7:0] partial;
      int         n;
      msg[0] = 8'h2C; msg[1] = 8'h35; msg[2] = 8'h45; msg[3] = 8'h44; msg[4] = 8'h2E;

      reset = 1'b1;
      rx    = 1'b1;
      repeat (3) @(negedge clock);
      check_eq("reset_dout", dout, 8'h00);
      check_eq("reset_rxready", rxready, 1'b0);
      check_eq("reset_frame_err", frame_err, 1'b0);
      check_eq("reset_parity_err", parity_err, 1'b0);
      check_eq("div_default", baud_divisor(100_000_000, 115_200), 54);
      reset = 1'b0;
      line_idle(BIT);

      // Single character
      send_good(8'h61);
      line_idle(BIT);

      // Back-to-back string, no idle between frames
      for (int i = 0; i < 5; i++) send_good(msg[i]);
      line_idle(BIT);

      // Stop bit low, line held low, then released; a clean frame follows
      send_frame(8'h43, 1'b0, good_parity(8'h43));
      drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b0);
      line_idle(BIT);
      send_good(8'h33);
      line_idle(BIT);

      // Short low glitch, well under half a bit, must be ignored
      rx = 1'b0;
      repeat (BIT / 4) @(negedge clock);
      line_idle(BIT);
      send_good(8'h7A);
      line_idle(BIT);

      // Reset in the middle of data bit 4
      partial = 8'hA5;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(partial[i]);
      rx = partial[4];
      repeat (BIT / 2) @(negedge clock);
      reset = 1'b1;
      #1;
      check_eq("midreset_dout", dout, 8'h00);
      check_eq("midreset_rxready", rxready, 1'b0);
      check_eq("midreset_frame_err", frame_err, 1'b0);
      check_eq("midreset_parity_err", parity_err, 1'b0);
      last_good = 8'h00;
      rx = 1'b1;
      repeat (5) @(negedge clock);
      reset = 1'b0;
      line_idle(2 * BIT);
      send_good(8'h73);
      line_idle(BIT);

      // Explicit parity bit values on the same byte
      if (PBITS == 1) begin
         send_frame(8'h7A, 1'b1, 1'b1);
         line_idle(BIT);
         send_frame(8'h7A, 1'b1, 1'b0);
         line_idle(BIT);
      end

      // Randomized traffic: good frames with random gaps, framing errors, glitches
      for (int k = 0; k < 16; k++) begin
         logic [7:0] b;
         int         mode;
         b    = 8'($urandom);
         mode = $urandom_range(0, 7);
         if (mode == 0) begin
            send_frame(b, 1'b0, good_parity(b));
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) drive_bit(1'b0);
            line_idle(BIT);
         end else if (mode == 1) begin
            rx = 1'b0;
            repeat ($urandom_range(1, BIT / 3)) @(negedge clock);
            line_idle(BIT);
         end else begin
            send_frame(b, 1'b1, good_parity(b) ^ ($urandom_range(0, 3) == 0));
            line_idle($urandom_range(0, 1) * $urandom_range(1, BIT / 2));
         end
      end
      line_idle(2 * BIT);

      check_eq("event_count", got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check_eq($sformatf("ev%0d_cycle", i), got_q[i].cyc, exp_q[i].cyc);
         check_eq($sformatf("ev%0d_flags", i), {got_q[i].rdy, got_q[i].ferr, got_q[i].perr},
                  {exp_q[i].rdy, exp_q[i].ferr, exp_q[i].perr});
         check_eq($sformatf("ev%0d_dout", i), got_q[i].data, exp_q[i].data);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
